reloj_soc_ram_tester: RTL

// - Avalon-MM master that drives the on-chip RAM slave (32-bit data, 11-bit word address, byte enables,

---
 rtl/reloj_soc_ram_pkg.sv | 31 +++
 rtl/reloj_soc_ram_chk.sv | 60 ++++++
 rtl/reloj_soc_ram_tester.sv | 122 ++++++++++++
 3 files changed

// File: rtl/reloj_soc_ram_pkg.sv
// Shared definitions for the RAM tester: default widths, command op codes,
// sequencer states and op decode helpers.
package reloj_soc_ram_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 12;

    typedef enum logic [1:0] {
        OP_FILL_CONST   = 2'd0,
        OP_FILL_INCR    = 2'd1,
        OP_VERIFY_INCR  = 2'd2,
        OP_VERIFY_CONST = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic logic op_is_write(input logic [1:0] op);
        return (op == OP_FILL_CONST) || (op == OP_FILL_INCR);
    endfunction

    function automatic logic op_is_incr(input logic [1:0] op);
        return (op == OP_FILL_INCR) || (op == OP_VERIFY_INCR);
    endfunction

endpackage

// File: rtl/reloj_soc_ram_chk.sv
// Read-verify stage: registers each accepted read, compares it against the
// returned word one cycle later and accumulates the mismatch statistics.
module reloj_soc_ram_chk
    import reloj_soc_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_expected,
    input  logic [DATA_W-1:0] i_readdata,
    output logic [LEN_W-1:0]  o_err_count,
    output logic [ADDR_W-1:0] o_first_err_addr
);

    localparam logic [LEN_W-1:0] MAX_ERR = LEN_W'(2 ** ADDR_W);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_expected;
    logic [LEN_W-1:0]  r_err_count;
    logic [ADDR_W-1:0] r_first_err_addr;
    logic              w_mismatch;

    assign w_mismatch = r_valid && (i_readdata != r_expected);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid          <= 1'b0;
            r_addr           <= '0;
            r_expected       <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_addr     <= i_addr;
                r_expected <= i_expected;
            end
            if (i_clear) begin
                r_err_count      <= '0;
                r_first_err_addr <= '0;
            end else if (w_mismatch) begin
                if (r_err_count == '0)
                    r_first_err_addr <= r_addr;
                if (r_err_count != MAX_ERR)
                    r_err_count <= r_err_count + LEN_W'(1);
            end
        end
    end

    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err_addr;

endmodule

// File: rtl/reloj_soc_ram_tester.sv
// Avalon-MM master that fills a RAM window with a constant/incrementing
// pattern or reads it back and counts mismatches.
module reloj_soc_ram_tester
    import reloj_soc_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [1:0]          i_op,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic [LEN_W-1:0]    i_len,
    input  logic [DATA_W-1:0]   i_pattern,
    output logic                o_busy,
    output logic                o_done,
    output logic [LEN_W-1:0]    o_err_count,
    output logic [ADDR_W-1:0]   o_first_err_addr,
    output logic [ADDR_W-1:0]   o_m_address,
    output logic [DATA_W/8-1:0] o_m_byteenable,
    output logic                o_m_chipselect,
    output logic                o_m_write,
    output logic [DATA_W-1:0]   o_m_writedata,
    input  logic [DATA_W-1:0]   i_m_readdata,
    input  logic                i_m_waitrequest
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_incr;
    logic              r_done;

    logic              w_cs;
    logic              w_accept;
    logic              w_last;
    logic              w_clear;
    logic [LEN_W-1:0]  w_len_sat;

    assign w_cs      = (r_state == ST_WRITE) || (r_state == ST_READ);
    assign w_accept  = w_cs && !i_m_waitrequest;
    assign w_last    = (r_remaining == LEN_W'(1));
    assign w_clear   = (r_state == ST_IDLE) && i_start;
    assign w_len_sat = (i_len > MAX_LEN) ? MAX_LEN : i_len;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_remaining <= '0;
            r_incr      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_addr      <= i_base_addr;
                        r_data      <= i_pattern;
                        r_remaining <= w_len_sat;
                        r_incr      <= op_is_incr(i_op);
                        if (i_len == '0)
                            r_done <= 1'b1;
                        else
                            r_state <= op_is_write(i_op) ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE, ST_READ: begin
                    // Everything advances only on an accepted beat, so a stall holds the bus.
                    if (w_accept) begin
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_data      <= r_data + DATA_W'(r_incr);
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_last) begin
                            if (r_state == ST_WRITE) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    reloj_soc_ram_chk #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_chk (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_clear          (w_clear),
        .i_valid          (w_accept && (r_state == ST_READ)),
        .i_addr           (r_addr),
        .i_expected       (r_data),
        .i_readdata       (i_m_readdata),
        .o_err_count      (o_err_count),
        .o_first_err_addr (o_first_err_addr)
    );

    assign o_busy         = (r_state != ST_IDLE);
    assign o_done         = r_done;
    assign o_m_address    = r_addr;
    assign o_m_byteenable = {(DATA_W/8){w_cs}};
    assign o_m_chipselect = w_cs;
    assign o_m_write      = (r_state == ST_WRITE);
    assign o_m_writedata  = r_data;

endmodule
